// File: rtl/s2mm_multibuf_b.sv
// s2mm_multibuf_b: AXI-Stream B-matrix writer that spreads beats round-robin over N2 banks
// into a ring of NUM_BUF buffers, with a one-cycle banked read port for the systolic array.
module s2mm_multibuf_b #(
   parameter int unsigned D_W     = 8,
   parameter int unsigned N2      = 4,
   parameter int unsigned NUM_BUF = 3,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned SIZE_W  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     s_axis_tdata,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   input  logic [SIZE_W-1:0]               block_sizedN2,
   input  logic                            rd_en,
   input  logic [ADDR_W-1:0]               rd_addr,
   input  logic                            rd_done,
   output logic [N2*D_W-1:0]               B_out,
   output logic                            B_valid,
   output logic                            buf_ready,
   output logic [SIZE_W+$clog2(N2)-1:0]    rd_len,
   output logic [$clog2(NUM_BUF+1)-1:0]    fill_count,
   output logic [$clog2(NUM_BUF)-1:0]      wr_buf_idx,
   output logic [$clog2(NUM_BUF)-1:0]      rd_buf_idx,
   output logic [1:0]                      err
);

   localparam int unsigned LEN_W  = SIZE_W + $clog2(N2);
   localparam int unsigned BANK_W = $clog2(N2);
   localparam int unsigned PTR_W  = $clog2(NUM_BUF);
   localparam int unsigned CNT_W  = $clog2(NUM_BUF + 1);
   localparam int unsigned MEM_AW = $clog2(NUM_BUF * DEPTH);

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_FILLING,
      BUF_COMMITTED,
      BUF_FULL
   } buf_st_e;

   buf_st_e            st_q [NUM_BUF];
   logic [LEN_W-1:0]   len_q [NUM_BUF];
   logic [LEN_W-1:0]   k_q;
   logic [SIZE_W-1:0]  size_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   fill_q;
   logic [1:0]         err_q;
   logic               rdy_q;
   logic               b_valid_q;

   logic               wr_en_q;
   logic [BANK_W-1:0]  wr_bank_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [PTR_W-1:0]   wr_buf_q;
   logic [D_W-1:0]     wr_data_q;
   logic [N2*D_W-1:0]  rd_data_q;
   logic [D_W-1:0]     mem_q [N2][NUM_BUF*DEPTH];

   logic               accept;
   logic               size_in_bad;
   logic [SIZE_W-1:0]  size_in;
   logic [SIZE_W-1:0]  size_cur;
   logic [LEN_W-1:0]   last_k;
   logic               close_blk;
   logic               release_ok;
   logic               rd_fire;
   logic [PTR_W-1:0]   wr_ptr_nxt;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [MEM_AW-1:0]  wr_maddr;
   logic [MEM_AW-1:0]  rd_maddr;
   logic               unused_tdata;

   assign unused_tdata = ^s_axis_tdata[31:D_W];

   // Acceptance, block-size sampling and close detection
   assign s_axis_tready = rdy_q & (fill_q != CNT_W'(NUM_BUF));
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign size_in_bad   = (block_sizedN2 == '0) || (block_sizedN2 > SIZE_W'(DEPTH));
   assign size_in       = size_in_bad ? SIZE_W'(DEPTH) : block_sizedN2;
   assign size_cur      = (k_q == '0) ? size_in : size_q;
   assign last_k        = LEN_W'(size_cur) * LEN_W'(N2) - LEN_W'(1);
   assign close_blk     = accept & (s_axis_tlast | (k_q == last_k));
   assign release_ok    = rd_done & (st_q[rd_ptr_q] == BUF_FULL);
   assign rd_fire       = rd_en & (st_q[rd_ptr_q] == BUF_FULL);
   assign wr_ptr_nxt    = (wr_ptr_q == PTR_W'(NUM_BUF - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
   assign rd_ptr_nxt    = (rd_ptr_q == PTR_W'(NUM_BUF - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
   assign wr_maddr      = MEM_AW'(wr_buf_q) * MEM_AW'(DEPTH) + MEM_AW'(wr_addr_q);
   assign rd_maddr      = MEM_AW'(rd_ptr_q) * MEM_AW'(DEPTH) + MEM_AW'(rd_addr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_BUF; i++) begin
            st_q[i]  <= BUF_EMPTY;
            len_q[i] <= '0;
         end
         k_q       <= '0;
         size_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         err_q     <= '0;
         rdy_q     <= 1'b0;
         b_valid_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_bank_q <= '0;
         wr_addr_q <= '0;
         wr_buf_q  <= '0;
         wr_data_q <= '0;
      end else begin
         rdy_q     <= 1'b1;
         b_valid_q <= rd_fire;
         wr_en_q   <= accept;
         if (accept) begin
            wr_bank_q <= BANK_W'(k_q % LEN_W'(N2));
            wr_addr_q <= ADDR_W'(k_q / LEN_W'(N2));
            wr_buf_q  <= wr_ptr_q;
            wr_data_q <= s_axis_tdata[D_W-1:0];
         end
         if (accept && (k_q == '0)) begin
            size_q <= size_in;
            if (size_in_bad) err_q[1] <= 1'b1;
         end
         // A committed buffer becomes readable one cycle after its close
         for (int unsigned i = 0; i < NUM_BUF; i++) begin
            if (st_q[i] == BUF_COMMITTED) st_q[i] <= BUF_FULL;
         end
         if (close_blk) begin
            k_q             <= '0;
            len_q[wr_ptr_q] <= k_q + LEN_W'(1);
            st_q[wr_ptr_q]  <= BUF_COMMITTED;
            wr_ptr_q        <= wr_ptr_nxt;
         end else if (accept) begin
            k_q <= k_q + LEN_W'(1);
            if (k_q == '0) st_q[wr_ptr_q] <= BUF_FILLING;
         end
         if (release_ok) begin
            st_q[rd_ptr_q] <= BUF_EMPTY;
            rd_ptr_q       <= rd_ptr_nxt;
         end else if (rd_done) begin
            err_q[0] <= 1'b1;
         end
         if (close_blk && !release_ok) fill_q <= fill_q + CNT_W'(1);
         else if (!close_blk && release_ok) fill_q <= fill_q - CNT_W'(1);
      end
   end

   // Bank storage: not reset, written one stage behind acceptance
   always_ff @(posedge clk) begin
      if (wr_en_q) mem_q[wr_bank_q][wr_maddr] <= wr_data_q;
      if (rd_fire) begin
         for (int unsigned b = 0; b < N2; b++) begin
            rd_data_q[b*D_W +: D_W] <= mem_q[BANK_W'(b)][rd_maddr];
         end
      end
   end

   assign B_out      = b_valid_q ? rd_data_q : '0;
   assign B_valid    = b_valid_q;
   assign buf_ready  = (st_q[rd_ptr_q] == BUF_FULL);
   assign rd_len     = len_q[rd_ptr_q];
   assign fill_count = fill_q;
   assign wr_buf_idx = wr_ptr_q;
   assign rd_buf_idx = rd_ptr_q;
   assign err        = err_q;

endmodule

// File: tb/tb_s2mm_multibuf_b.sv
// Directed bench for s2mm_multibuf_b: block fill, ring wrap, early tlast, simultaneous
// close/release, error flags and reset in the middle of a block.
module tb_s2mm_multibuf_b;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [15:0] block_sizedN2;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic        rd_done;
   logic [31:0] B_out;
   logic        B_valid;
   logic        buf_ready;
   logic [17:0] rd_len;
   logic [1:0]  fill_count;
   logic [1:0]  wr_buf_idx;
   logic [1:0]  rd_buf_idx;
   logic [1:0]  err;

   int total = 0;
   int bad   = 0;

   s2mm_multibuf_b #(
      .D_W(8), .N2(4), .NUM_BUF(3), .DEPTH(1024), .ADDR_W(10), .SIZE_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .block_sizedN2(block_sizedN2),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
      .B_out(B_out), .B_valid(B_valid), .buf_ready(buf_ready), .rd_len(rd_len),
      .fill_count(fill_count), .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and hold it until accepted (bounded)
   task automatic push(input logic [31:0] d, input logic last);
      int n;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 64) begin
         step();
         n++;
      end
      if (!s_axis_tready) begin
         total++; bad++;
         $display("FAIL push_timeout act_ready=%0b exp_ready=1", s_axis_tready);
      end
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic release_buf();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(); step();
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready act=%0b exp=0", s_axis_tready); end
      total++; if (B_valid !== 1'b0) begin bad++; $display("FAIL rst_bvalid act=%0b exp=0", B_valid); end
      total++; if (B_out !== 32'h0) begin bad++; $display("FAIL rst_bout act=%h exp=0", B_out); end
      total++; if (buf_ready !== 1'b0) begin bad++; $display("FAIL rst_bufready act=%0b exp=0", buf_ready); end
      total++; if ({fill_count, wr_buf_idx, rd_buf_idx} !== 6'h0) begin bad++; $display("FAIL rst_ptrs act=%0d/%0d/%0d exp=0/0/0", fill_count, wr_buf_idx, rd_buf_idx); end
      total++; if (rd_len !== 18'd0) begin bad++; $display("FAIL rst_rdlen act=%0d exp=0", rd_len); end
      total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err act=%b exp=00", err); end
      rst = 1'b1;
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_rel_tready0 act=%0b exp=0", s_axis_tready); end
      step();
      total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_rel_tready1 act=%0b exp=1", s_axis_tready); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++) push(32'(i), 1'b0);
      total++; if (fill_count !== 2'd1) begin bad++; $display("FAIL basic_fill act=%0d exp=1", fill_count); end
      total++; if (wr_buf_idx !== 2'd1) begin bad++; $display("FAIL basic_wrptr act=%0d exp=1", wr_buf_idx); end
      total++; if (buf_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_early act=%0b exp=0", buf_ready); end
      step();
      total++; if (buf_ready !== 1'b1) begin bad++; $display("FAIL basic_ready act=%0b exp=1", buf_ready); end
      total++; if (rd_len !== 18'd8) begin bad++; $display("FAIL basic_rdlen act=%0d exp=8", rd_len); end
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      total++; if (B_valid !== 1'b1) begin bad++; $display("FAIL basic_bvalid act=%0b exp=1", B_valid); end
      total++; if (B_out !== 32'h03020100) begin bad++; $display("FAIL basic_addr0 act=%h exp=03020100", B_out); end
      rd_addr = 10'd1;
      step();
      total++; if (B_out !== 32'h07060504) begin bad++; $display("FAIL basic_addr1 act=%h exp=07060504", B_out); end
      rd_en = 1'b0;
      step();
      total++; if ({B_valid, B_out} !== 33'h0) begin bad++; $display("FAIL basic_idle act=%0b/%h exp=0/0", B_valid, B_out); end
      release_buf();
      total++; if ({fill_count, rd_buf_idx} !== {2'd0, 2'd1}) begin bad++; $display("FAIL basic_release act=%0d/%0d exp=0/1", fill_count, rd_buf_idx); end
      total++; if (buf_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_after act=%0b exp=0", buf_ready); end
      total++; if (err !== 2'b00) begin bad++; $display("FAIL basic_err act=%b exp=00", err); end
   endtask

   task automatic test_early_tlast();
      for (int i = 0; i < 5; i++) push(32'(10 + i), (i == 4));
      total++; if (wr_buf_idx !== 2'd2) begin bad++; $display("FAIL tlast_wrptr act=%0d exp=2", wr_buf_idx); end
      step();
      total++; if (rd_len !== 18'd5) begin bad++; $display("FAIL tlast_rdlen act=%0d exp=5", rd_len); end
      rd_en = 1'b1; rd_addr = 10'd1;
      step();
      total++; if (B_out[7:0] !== 8'd14) begin bad++; $display("FAIL tlast_bank0_addr1 act=%0d exp=14", B_out[7:0]); end
      rd_addr = 10'd0;
      step();
      total++; if (B_out !== 32'h0D0C0B0A) begin bad++; $display("FAIL tlast_addr0 act=%h exp=0d0c0b0a", B_out); end
      rd_en = 1'b0;
      release_buf();
      for (int i = 0; i < 8; i++) push(32'(20 + i), 1'b0);
      step();
      total++; if ({rd_buf_idx, rd_len} !== {2'd2, 18'd8}) begin bad++; $display("FAIL tlast_next_len act=%0d/%0d exp=2/8", rd_buf_idx, rd_len); end
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      total++; if (B_out !== 32'h17161514) begin bad++; $display("FAIL tlast_next_addr0 act=%h exp=17161514", B_out); end
      rd_en = 1'b0;
      release_buf();
      total++; if ({wr_buf_idx, rd_buf_idx, fill_count} !== 6'h0) begin bad++; $display("FAIL tlast_end act=%0d/%0d/%0d exp=0/0/0", wr_buf_idx, rd_buf_idx, fill_count); end
   endtask

   task automatic test_ring_fill();
      for (int i = 0; i < 24; i++) push(32'(8'h40 + i), 1'b0);
      total++; if (fill_count !== 2'd3) begin bad++; $display("FAIL ring_fill act=%0d exp=3", fill_count); end
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL ring_tready_low act=%0b exp=0", s_axis_tready); end
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h99;
      step(); step();
      s_axis_tvalid = 1'b0;
      total++; if ({fill_count, wr_buf_idx, s_axis_tready} !== {2'd3, 2'd0, 1'b0}) begin bad++; $display("FAIL ring_hold act=%0d/%0d/%0b exp=3/0/0", fill_count, wr_buf_idx, s_axis_tready); end
      release_buf();
      total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL ring_tready_back act=%0b exp=1", s_axis_tready); end
      total++; if (rd_buf_idx !== 2'd1) begin bad++; $display("FAIL ring_rdptr act=%0d exp=1", rd_buf_idx); end
      for (int i = 24; i < 32; i++) push(32'(8'h40 + i), 1'b0);
      total++; if ({fill_count, wr_buf_idx} !== {2'd3, 2'd1}) begin bad++; $display("FAIL ring_refill act=%0d/%0d exp=3/1", fill_count, wr_buf_idx); end
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      total++; if (B_out !== 32'h4B4A4948) begin bad++; $display("FAIL ring_buf1 act=%h exp=4b4a4948", B_out); end
      rd_en = 1'b0;
      release_buf();
      release_buf();
      total++; if (rd_buf_idx !== 2'd0) begin bad++; $display("FAIL ring_wrap_rdptr act=%0d exp=0", rd_buf_idx); end
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      total++; if (B_out !== 32'h5B5A5958) begin bad++; $display("FAIL ring_buf0_addr0 act=%h exp=5b5a5958", B_out); end
      rd_addr = 10'd1;
      step();
      total++; if (B_out !== 32'h5F5E5D5C) begin bad++; $display("FAIL ring_buf0_addr1 act=%h exp=5f5e5d5c", B_out); end
      rd_en = 1'b0;
      release_buf();
      total++; if ({fill_count, rd_buf_idx, err} !== {2'd0, 2'd1, 2'b00}) begin bad++; $display("FAIL ring_end act=%0d/%0d/%b exp=0/1/00", fill_count, rd_buf_idx, err); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) push(32'(8'h60 + i), 1'b0);
      step();
      for (int i = 0; i < 7; i++) push(32'(8'h70 + i), 1'b0);
      total++; if ({fill_count, buf_ready} !== {2'd1, 1'b1}) begin bad++; $display("FAIL simul_pre act=%0d/%0b exp=1/1", fill_count, buf_ready); end
      s_axis_tdata = 32'h77; s_axis_tvalid = 1'b1; rd_done = 1'b1;
      total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL simul_tready act=%0b exp=1", s_axis_tready); end
      step();
      s_axis_tvalid = 1'b0; rd_done = 1'b0;
      total++; if (fill_count !== 2'd1) begin bad++; $display("FAIL simul_fill act=%0d exp=1", fill_count); end
      total++; if ({wr_buf_idx, rd_buf_idx} !== {2'd0, 2'd2}) begin bad++; $display("FAIL simul_ptrs act=%0d/%0d exp=0/2", wr_buf_idx, rd_buf_idx); end
      total++; if (err !== 2'b00) begin bad++; $display("FAIL simul_err act=%b exp=00", err); end
      step();
      total++; if ({buf_ready, rd_len} !== {1'b1, 18'd8}) begin bad++; $display("FAIL simul_ready act=%0b/%0d exp=1/8", buf_ready, rd_len); end
      rd_en = 1'b1; rd_addr = 10'd1;
      step();
      total++; if (B_out !== 32'h77767574) begin bad++; $display("FAIL simul_data act=%h exp=77767574", B_out); end
      rd_en = 1'b0;
      release_buf();
   endtask

   task automatic test_errors();
      release_buf();
      total++; if (err !== 2'b01) begin bad++; $display("FAIL err_rd_done act=%b exp=01", err); end
      total++; if ({rd_buf_idx, fill_count} !== {2'd0, 2'd0}) begin bad++; $display("FAIL err_rd_done_ptr act=%0d/%0d exp=0/0", rd_buf_idx, fill_count); end
      block_sizedN2 = 16'd0;
      push(32'd0, 1'b0);
      block_sizedN2 = 16'd2;
      total++; if (err !== 2'b11) begin bad++; $display("FAIL err_size act=%b exp=11", err); end
      for (int i = 1; i < 4095; i++) push(32'(i), 1'b0);
      total++; if ({fill_count, wr_buf_idx} !== {2'd0, 2'd0}) begin bad++; $display("FAIL err_not_closed act=%0d/%0d exp=0/0", fill_count, wr_buf_idx); end
      push(32'd4095, 1'b0);
      total++; if ({fill_count, wr_buf_idx} !== {2'd1, 2'd1}) begin bad++; $display("FAIL err_closed act=%0d/%0d exp=1/1", fill_count, wr_buf_idx); end
      step();
      total++; if (rd_len !== 18'd4096) begin bad++; $display("FAIL err_rdlen act=%0d exp=4096", rd_len); end
      rd_en = 1'b1; rd_addr = 10'd1023;
      step();
      total++; if (B_out !== 32'hFFFEFDFC) begin bad++; $display("FAIL err_last_word act=%h exp=fffefdfc", B_out); end
      rd_en = 1'b0;
      release_buf();
      total++; if ({rd_buf_idx, err} !== {2'd1, 2'b11}) begin bad++; $display("FAIL err_end act=%0d/%b exp=1/11", rd_buf_idx, err); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) push(32'(8'h80 + i), 1'b0);
      s_axis_tdata = 32'h85; s_axis_tvalid = 1'b1;
      rst = 1'b0;
      #1;
      s_axis_tvalid = 1'b0;
      total++; if ({s_axis_tready, B_valid, buf_ready, err} !== 5'h0) begin bad++; $display("FAIL mid_rst_flags act=%0b/%0b/%0b/%b exp=0/0/0/00", s_axis_tready, B_valid, buf_ready, err); end
      total++; if ({fill_count, wr_buf_idx, rd_buf_idx} !== 6'h0) begin bad++; $display("FAIL mid_rst_ptrs act=%0d/%0d/%0d exp=0/0/0", fill_count, wr_buf_idx, rd_buf_idx); end
      total++; if ({B_out, rd_len} !== 50'h0) begin bad++; $display("FAIL mid_rst_data act=%h/%0d exp=0/0", B_out, rd_len); end
      step(); step();
      rst = 1'b1;
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL mid_rel_tready0 act=%0b exp=0", s_axis_tready); end
      step();
      total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL mid_rel_tready1 act=%0b exp=1", s_axis_tready); end
      for (int i = 0; i < 8; i++) push(32'(8'hA0 + i), 1'b0);
      total++; if ({fill_count, wr_buf_idx} !== {2'd1, 2'd1}) begin bad++; $display("FAIL mid_block act=%0d/%0d exp=1/1", fill_count, wr_buf_idx); end
      step();
      rd_en = 1'b1; rd_addr = 10'd0;
      step();
      total++; if (B_out !== 32'hA3A2A1A0) begin bad++; $display("FAIL mid_data act=%h exp=a3a2a1a0", B_out); end
      rd_en = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      block_sizedN2 = 16'd2;
      rd_en         = 1'b0;
      rd_addr       = '0;
      rd_done       = 1'b0;
      test_reset();
      test_basic();
      test_early_tlast();
      test_ring_fill();
      test_simultaneous();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s2mm_multibuf_b.md
# s2mm_multibuf_B

Parametrised N-way successor to the two-way ping-pong B-matrix buffer in the S2MM front end. It accepts an AXI-Stream of B-matrix words and distributes them round-robin across `N2` banks. Blocks are stored into a ring of `NUM_BUF` buffers, so the writer can run up to `NUM_BUF` blocks ahead of the multiply array. The block sits between the S2MM DMA and the systolic array's B-side read port, and runs in a single clock domain.

## Interface
- `D_W`, 8, stored element width; the low `D_W` bits of `tdata` are kept.
- `N2`, 4, number of banks (array columns), ≥2.
- `NUM_BUF`, 3, buffers in the ring, 2..8.
- `DEPTH`, 1024, words per bank per buffer.
- `ADDR_W`, 10, `$clog2(DEPTH)`.
- `SIZE_W`, 16, width of size configuration.
---
- `clk`  input  1  clock.
- `rst`  input  1  asynchronous, active-low reset.
- `s_axis_tdata`  input  32  stream data.
- `s_axis_tvalid`  input  1  stream valid.
- `s_axis_tlast`  input  1  early end-of-block marker.
- `s_axis_tready`  output  1  stream ready.
- `block_sizedN2`  input  SIZE_W  words per bank per block.
- `rd_en`  input  1  read request.
- `rd_addr`  input  ADDR_W  bank address to read.
- `rd_done`  input  1  pulse: reader releases the current buffer.
- `B_out`  output  N2*D_W  packed bank outputs; bank k is at `[k*D_W +: D_W]`, signed.
- `B_valid`  output  1  `B_out` holds valid data.
- `buf_ready`  output  1  the buffer at the read pointer is full and readable.
- `rd_len`  output  SIZE_W+$clog2(N2)  beats stored in the read buffer.
- `fill_count`  output  $clog2(NUM_BUF+1)  committed buffers.
- `wr_buf_idx`, `rd_buf_idx`  output  $clog2(NUM_BUF)  ring pointers.
- `err`  output  2  sticky flags: [0] `rd_done` arrived with no full buffer; [1] bad `block_sizedN2`.

## Operation
- **Write path**
  - Beat k of a block (k from 0) goes to bank k mod N2, address k/N2, in buffer `wr_buf_idx`.
  - Memory is one registered write stage behind acceptance.
  - `block_sizedN2` is sampled on the first beat of each block; changes mid-block are ignored.
  - A value of 0 or greater than `DEPTH` sets `err[1]` and is treated as `DEPTH`.
- **Block close**
  - A block closes on the beat with k = sized×N2−1, or on any accepted beat with `tlast`, whichever comes first.
  - On close: `len[wr]` ← k+1, `wr_buf_idx` advances modulo `NUM_BUF`, `fill_count` increments, k resets to 0.
- **Backpressure:** `s_axis_tready` = `rdy_q` & (`fill_count` != `NUM_BUF`). Accepting a beat with tready low is impossible by construction.
- **Read path**
  - `buf_ready` = `full[rd_buf_idx]`.
  - `rd_en` is honoured only while `buf_ready` is high; it reads all N2 banks at `rd_addr` of buffer `rd_buf_idx`.
  - Otherwise `B_valid` stays 0 and `B_out` is 0.
  - `B_out` is forced to 0 whenever `B_valid` is 0.
- **Release**
  - `rd_done` with `full[rd_buf_idx]` set: clear that flag, advance `rd_buf_idx` modulo `NUM_BUF`, decrement `fill_count`.
  - `rd_done` otherwise: ignored, and `err[0]` is set.
- **Per-buffer state machine:** EMPTY → FILLING (first beat) → COMMITTED (close; counted, not yet readable) → FULL (one cycle later) → EMPTY (on `rd_done`).
- **Simultaneous close and `rd_done`:** `fill_count` is unchanged and both pointers advance.
- **Reuse of a released buffer:** a buffer released by `rd_done` at edge t may take new data from edge t+1.

## Timing
- **Reset (rst=0):** `s_axis_tready`=0, `B_valid`=0, `B_out`=0, `buf_ready`=0, `fill_count`=0, both pointers 0, `rd_len`=0, `err`=0, all full flags clear, beat counter 0. Memory contents are not cleared.
- **After reset release:** `rdy_q` rises at the first edge after deassertion, so tready is high from the second cycle.
- **Reset mid-block:** the partial block is discarded.
- **Write latency:** beat accepted at edge t is written at edge t+1.
- **Closing beat at edge t:**
  - `fill_count` is updated at t.
  - `full` rises at t+1, so `buf_ready` is high after t+1.
  - `rd_en` sampled at t+1 returns the new data at t+2.
- **Read latency:** `rd_en` sampled at edge t → `B_out`/`B_valid` valid after edge t+1, one cycle.
- **Full ring:** when `fill_count` reaches `NUM_BUF` on close at edge t, tready is low from that cycle. It returns high the cycle after the edge that samples `rd_done`.
- **`rd_len`** follows `rd_buf_idx` combinationally from the `len` registers.

## Test plan
Parameters for all scenarios: N2=4, NUM_BUF=3, D_W=8, `block_sizedN2`=2 (8 beats per block).
- **Basic block:** stream 0..7 with no tlast → `buf_ready` at edge 9. `rd_en` at addr 0 then addr 1 gives `B_out` {3,2,1,0} then {7,6,5,4} (bank3..bank0), `rd_len`=8.
- **Ring fill:** stream 24 beats with no reads → `fill_count` 3 and tready low after beat 23. One `rd_done` makes tready high the next cycle; beats 24..31 land in buffer 0.
- **Early tlast:** `tlast` on beat 4 → `rd_len`=5; bank0 addr1 = 4; the next block starts at bank0 addr0 of buffer 1.
- **Simultaneous events:** `rd_done` on the same edge as the closing beat with `fill_count`=1 → `fill_count` stays 1, both pointers increment, no error.
- **Errors:** `rd_done` while empty → `err[0]`=1 and the pointer is unchanged. `block_sizedN2`=0 → `err[1]`=1 and the block closes after 4096 beats.
- **Reset mid-operation:** pull `rst` low during beat 5 of buffer 1 → all outputs at reset values. tready is high the second cycle after release, and the next beat goes to buffer 0, bank0, addr0.
